ti_roic_cfg_scheduler: RTL and testbench
========================================

# ti_roic_cfg_scheduler

Arbitrates ROIC register-write requests from several requesters, such as the host register bank and a power-up init-table walker, onto the single TI ROIC register bus. That bus is `ti_roic_reg_addr` / `ti_roic_reg_data`, with `ti_roic_reg_addr[15]` acting as the write enable. The block sequences each write as setup, enable strobe, then a guard gap long enough for the SPI frame to complete. This keeps the downstream rising-edge detector and SPI engine from ever seeing overlapping or too-short enables. It runs in the `clk_5mhz` domain, directly upstream of the TI ROIC integration block.

## Interface
Parameters:
- `NUM_REQ`, default 2: number of requesters; legal range 1..8.
- `SETUP_CYC`, default 2: cycles address/data are stable before the enable rises; must be ≥1.
- `EN_CYC`, default 4: cycles the enable is held high; must be ≥2, so the two-flop edge detector downstream sees it.
- `GAP_CYC`, default 40: cycles the enable is low after the strobe, covering the SPI frame; must be ≥1.

Ports:
- `clk_5mhz`, in, 1: the single clock.
- `deser_reset_n`, in, 1: asynchronous, active-low reset.
- `req_valid`, in, NUM_REQ: per-requester write request.
- `req_addr`, in, NUM_REQ*8: ROIC register address; requester i occupies bits [8i+7:8i].
- `req_data`, in, NUM_REQ*16: write data; requester i occupies bits [16i+15:16i].
- `req_ready`, out, NUM_REQ: one-hot accept. The request is consumed in the cycle where valid and ready are both high.
- `hold_off`, in, 1: when high, no new grant is issued (e.g. during frame readout).
- `ti_roic_reg_addr`, out, 16: bit 15 is the enable, bits 14:8 are always 0, bits 7:0 are the address.
- `ti_roic_reg_data`, out, 16: write data.
- `busy`, out, 1: high whenever the state is not IDLE.
- `cmd_done`, out, 1: one-cycle pulse on the last GAP cycle.
- `done_id`, out, clog2(NUM_REQ) (min 1): index of the requester whose command completed; valid while `cmd_done` is high.

## Operation
- **States:** IDLE → SETUP → STROBE → GAP → IDLE.
- **Cycle counter:** a single down-counter, wide enough for max(SETUP_CYC, EN_CYC, GAP_CYC), is loaded on every state entry.
- **IDLE:**
  - When `hold_off`=0 and any `req_valid` is set, the round-robin winner g gets `req_ready[g]`=1, combinationally, in the same cycle.
  - On that clock edge, `req_addr`/`req_data` of g are latched into the output registers, g is recorded, and the state moves to SETUP.
  - `req_ready` is 0 in every other state and whenever `hold_off`=1.
- **Round-robin arbitration:**
  - A pointer holds the highest-priority index. The search order is ptr, ptr+1, …, wrapping modulo NUM_REQ.
  - After a grant to g, ptr becomes (g+1) mod NUM_REQ. Ptr is unchanged when there is no grant.
- **SETUP:** lasts SETUP_CYC cycles; `ti_roic_reg_addr[15]`=0 and address/data are stable.
- **STROBE:** lasts EN_CYC cycles; `ti_roic_reg_addr[15]`=1; address/data unchanged.
- **GAP:** lasts GAP_CYC cycles; `ti_roic_reg_addr[15]`=0. `cmd_done`=1 and `done_id`=g on the final GAP cycle, then the state returns to IDLE.
- **Output hold:** address/data outputs keep the last command's values until the next grant; they are not cleared.
- **`hold_off` scope:** it only blocks new grants. A command already in flight always completes all three phases.
- **Request changes:** `req_valid` dropping or `req_addr`/`req_data` changing after acceptance has no effect on the in-flight command.
- **Reset:** asserting `deser_reset_n` low at any time, including mid-STROBE, immediately forces:
  - state = IDLE, ptr = 0
  - all outputs to their reset values; the enable falls asynchronously.
  - Any in-flight command is lost and no `cmd_done` is produced.
- **Reset values:** `ti_roic_reg_addr`=16'h0000, `ti_roic_reg_data`=16'h0000, `req_ready`=0, `busy`=0, `cmd_done`=0, `done_id`=0.

## Timing
- **Latency:** with the accept in cycle T, the enable is high in cycles T+1+SETUP_CYC … T+SETUP_CYC+EN_CYC.
- **`cmd_done`:** high in cycle T+SETUP_CYC+EN_CYC+GAP_CYC.
- **Next accept:** the earliest is cycle T+SETUP_CYC+EN_CYC+GAP_CYC+1, giving throughput of one command per 1+SETUP_CYC+EN_CYC+GAP_CYC cycles (47 with defaults).
- **`busy`:** high from T+1 through the `cmd_done` cycle inclusive.
- **Registered outputs:** all outputs except `req_ready` are registered. `req_ready` is a combinational function of state, `hold_off`, `req_valid` and ptr.
- **Simultaneous events:**
  - `hold_off` rising in the same cycle as a would-be grant suppresses that grant.
  - A valid that is already high when `cmd_done` pulses is not granted until the following IDLE cycle.

## Test plan
- **Single request:** `req_valid`=01, addr 8'h1A, data 16'hBEEF → `req_ready[0]` for 1 cycle. `ti_roic_reg_addr` = 16'h001A for 2 cycles, 16'h801A for 4 cycles, then 16'h001A. `cmd_done` arrives 46 cycles after accept with `done_id`=0.
- **Round-robin:** both requesters held valid for 4 commands → grants in order 0,1,0,1. Accepts are exactly 47 cycles apart and the enable is never high for more than 4 consecutive cycles.
- **`hold_off`:** assert `hold_off` during STROBE of a command with requester 1 pending → the current command completes with `cmd_done`. No `req_ready` while `hold_off`=1; requester 1 is granted in the first cycle after `hold_off` falls.
- **Input change after accept:** change `req_addr[7:0]` to 8'h55 one cycle after accept of 8'h10 → outputs stay at 8'h10 for the whole command.
- **Reset mid-STROBE:** pulse `deser_reset_n` low while the enable is high → `ti_roic_reg_addr`=0 and `busy`=0 immediately, and no `cmd_done`. After release, a new request is granted to requester 0 (ptr reset).
- **Parameter sweep:** run with NUM_REQ=3, SETUP_CYC=1, EN_CYC=2, GAP_CYC=1 → 5-cycle command period; ptr wraps 2→0 correctly.

Source files
------------

// File: rtl/ti_roic_cfg_scheduler_if.sv
// Request handshake, ROIC register bus and status signals of the
// ROIC configuration write scheduler. The scheduler takes the slave side.
interface ti_roic_cfg_scheduler_if #(
  parameter int NUM_REQ = 2
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*8-1:0]  req_addr;
  logic [NUM_REQ*16-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  hold_off;
  logic [15:0]           ti_roic_reg_addr;
  logic [15:0]           ti_roic_reg_data;
  logic                  busy;
  logic                  cmd_done;
  logic [ID_W-1:0]       done_id;

  modport master (
    output req_valid, req_addr, req_data, hold_off,
    input  req_ready, ti_roic_reg_addr, ti_roic_reg_data, busy, cmd_done, done_id
  );

  modport slave (
    input  req_valid, req_addr, req_data, hold_off,
    output req_ready, ti_roic_reg_addr, ti_roic_reg_data, busy, cmd_done, done_id
  );
endinterface

// File: rtl/ti_roic_cfg_scheduler.sv
// Round-robin scheduler for TI ROIC register writes. Each accepted write is
// played out as address/data setup, an enable strobe on addr[15], then a
// quiet gap covering the downstream SPI frame, so the edge detector never
// sees overlapping or short enables.
// Legal parameters: NUM_REQ 1..8, SETUP_CYC >= 1, EN_CYC >= 2, GAP_CYC >= 1.
module ti_roic_cfg_scheduler #(
  parameter int NUM_REQ   = 2,
  parameter int SETUP_CYC = 2,
  parameter int EN_CYC    = 4,
  parameter int GAP_CYC   = 40
) (
  input  logic clk_5mhz,
  input  logic deser_reset_n,
  ti_roic_cfg_scheduler_if.slave bus
);
  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_MAX = (SETUP_CYC > EN_CYC) ?
                           ((SETUP_CYC > GAP_CYC) ? SETUP_CYC : GAP_CYC) :
                           ((EN_CYC > GAP_CYC) ? EN_CYC : GAP_CYC);
  // counter holds phase length minus one; EN_CYC >= 2 keeps this >= 1
  localparam int CNT_W   = $clog2(CNT_MAX);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, GAP} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    gnt_id;
  logic [ID_W-1:0]    gnt_q;
  logic               gnt_vld;
  logic               accept;
  logic [NUM_REQ-1:0] ready;
  int                 idx;
  logic [7:0]         addr_q;
  logic [15:0]        data_q;
  logic               en_q;
  logic               busy_q;
  logic               done_q;

  // round-robin search starting at ptr, wrapping modulo NUM_REQ
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!gnt_vld && bus.req_valid[idx]) begin
        gnt_vld = 1'b1;
        gnt_id  = ID_W'(idx);
      end
    end
  end

  assign accept = (state == IDLE) && !bus.hold_off && gnt_vld;

  // one-hot ready toward the winner, only while a grant is actually issued
  always_comb begin
    ready = '0;
    if (accept) ready[gnt_id] = 1'b1;
  end

  // phase sequencing; the counter is reloaded with (length-1) on each entry
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = SETUP;
          cnt_nxt   = CNT_W'(SETUP_CYC - 1);
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          state_nxt = STROBE;
          cnt_nxt   = CNT_W'(EN_CYC - 1);
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      STROBE: begin
        if (cnt == '0) begin
          state_nxt = GAP;
          cnt_nxt   = CNT_W'(GAP_CYC - 1);
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      GAP: begin
        if (cnt == '0) state_nxt = IDLE;
        else           cnt_nxt   = cnt - 1'b1;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // state, counter and arbitration pointer
  always_ff @(posedge clk_5mhz or negedge deser_reset_n) begin
    if (!deser_reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) ptr <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
    end
  end

  // registered bus outputs: command captured at accept and held until the
  // next one; status flags are decoded from the upcoming state
  always_ff @(posedge clk_5mhz or negedge deser_reset_n) begin
    if (!deser_reset_n) begin
      addr_q <= '0;
      data_q <= '0;
      gnt_q  <= '0;
      en_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      if (accept) begin
        addr_q <= bus.req_addr[8*gnt_id +: 8];
        data_q <= bus.req_data[16*gnt_id +: 16];
        gnt_q  <= gnt_id;
      end
      en_q   <= (state_nxt == STROBE);
      busy_q <= (state_nxt != IDLE);
      done_q <= (state_nxt == GAP) && (cnt_nxt == '0);
    end
  end

  assign bus.req_ready        = ready;
  assign bus.ti_roic_reg_addr = {en_q, 7'b0, addr_q};
  assign bus.ti_roic_reg_data = data_q;
  assign bus.busy             = busy_q;
  assign bus.cmd_done         = done_q;
  assign bus.done_id          = gnt_q;
endmodule

// File: tb/tb_ti_roic_cfg_scheduler.sv
// Bench for ti_roic_cfg_scheduler: default instance plus a small-parameter
// instance, each checked cycle by cycle against a command-timeline model.
module tb_ti_roic_cfg_scheduler;
  logic clk_5mhz      = 1'b0;
  logic deser_reset_n = 1'b0;
  always #5 clk_5mhz = ~clk_5mhz;

  ti_roic_cfg_scheduler_if #(.NUM_REQ(2)) ifa();
  ti_roic_cfg_scheduler_if #(.NUM_REQ(3)) ifb();

  ti_roic_cfg_scheduler dut_a (
    .clk_5mhz(clk_5mhz), .deser_reset_n(deser_reset_n), .bus(ifa)
  );
  ti_roic_cfg_scheduler #(.NUM_REQ(3), .SETUP_CYC(1), .EN_CYC(2), .GAP_CYC(1)) dut_b (
    .clk_5mhz(clk_5mhz), .deser_reset_n(deser_reset_n), .bus(ifb)
  );

  int n_vec = 0;
  int n_err = 0;

  // per-instance parameters
  int P_N[2] = '{2, 3};
  int P_S[2] = '{2, 1};
  int P_E[2] = '{4, 2};
  int P_G[2] = '{40, 1};

  // model: a command in flight is described only by its age in cycles since accept
  bit          m_fl[2];
  int          m_age[2];
  int          m_id[2];
  int          m_ptr[2];
  logic [7:0]  m_addr[2];
  logic [15:0] m_data[2];
  logic [7:0]  e_rdy[2];
  logic [44:0] e_vec[2];

  function automatic logic [7:0] in_vld(int i);
    return (i == 0) ? 8'(ifa.req_valid) : 8'(ifb.req_valid);
  endfunction
  function automatic logic in_hold(int i);
    return (i == 0) ? ifa.hold_off : ifb.hold_off;
  endfunction
  function automatic logic [63:0] in_addr(int i);
    return (i == 0) ? 64'(ifa.req_addr) : 64'(ifb.req_addr);
  endfunction
  function automatic logic [127:0] in_data(int i);
    return (i == 0) ? 128'(ifa.req_data) : 128'(ifb.req_data);
  endfunction

  // DUT outputs packed as {ready, addr16, data16, busy, done, id-when-done}
  function automatic logic [44:0] obs(int i);
    if (i == 0)
      return {8'(ifa.req_ready), ifa.ti_roic_reg_addr, ifa.ti_roic_reg_data, ifa.busy,
              ifa.cmd_done, ifa.cmd_done ? 3'(ifa.done_id) : 3'b0};
    return {8'(ifb.req_ready), ifb.ti_roic_reg_addr, ifb.ti_roic_reg_data, ifb.busy,
            ifb.cmd_done, ifb.cmd_done ? 3'(ifb.done_id) : 3'b0};
  endfunction

  task automatic mdl_reset(int i);
    m_fl[i] = 1'b0; m_age[i] = 0; m_id[i] = 0; m_ptr[i] = 0;
    m_addr[i] = '0; m_data[i] = '0; e_rdy[i] = '0;
  endtask

  // expected outputs for the current cycle from current inputs
  task automatic mdl_eval(int i);
    logic [7:0] v;
    logic       en, done;
    int         tot;
    v   = in_vld(i);
    tot = P_S[i] + P_E[i] + P_G[i];
    e_rdy[i] = '0;
    if (!m_fl[i] && !in_hold(i))
      for (int k = 0; k < P_N[i]; k++) begin
        int j;
        j = (m_ptr[i] + k) % P_N[i];
        if (e_rdy[i] == 0 && v[j]) e_rdy[i] = 8'(1) << j;
      end
    en   = m_fl[i] && (m_age[i] > P_S[i]) && (m_age[i] <= P_S[i] + P_E[i]);
    done = m_fl[i] && (m_age[i] == tot);
    e_vec[i] = {e_rdy[i], en, 7'b0, m_addr[i], m_data[i], m_fl[i], done,
                done ? 3'(m_id[i]) : 3'b0};
  endtask

  // advance the model across a clock edge
  task automatic mdl_step(int i);
    logic [63:0]  a;
    logic [127:0] d;
    if (e_rdy[i] != 0) begin
      for (int k = 0; k < 8; k++) if (e_rdy[i][k]) m_id[i] = k;
      a = in_addr(i);
      d = in_data(i);
      m_addr[i] = a[8*m_id[i] +: 8];
      m_data[i] = d[16*m_id[i] +: 16];
      m_fl[i]   = 1'b1;
      m_age[i]  = 1;
      m_ptr[i]  = (m_id[i] + 1) % P_N[i];
    end else if (m_fl[i]) begin
      m_age[i]++;
      if (m_age[i] > P_S[i] + P_E[i] + P_G[i]) m_fl[i] = 1'b0;
    end
  endtask

  task automatic zero_inputs();
    ifa.req_valid = '0; ifa.req_addr = '0; ifa.req_data = '0; ifa.hold_off = 1'b0;
    ifb.req_valid = '0; ifb.req_addr = '0; ifb.req_data = '0; ifb.hold_off = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk_5mhz);
    zero_inputs();
    deser_reset_n = 1'b0;
    @(negedge clk_5mhz);
    deser_reset_n = 1'b1;
    mdl_reset(0);
    mdl_reset(1);
  endtask

  task automatic test_reset();
    zero_inputs();
    deser_reset_n = 1'b0;
    @(negedge clk_5mhz); #1;
    n_vec++;
    if (obs(0) !== 45'h0) begin n_err++; $display("FAIL reset_a got=%h want=0", obs(0)); end
    n_vec++;
    if (obs(1) !== 45'h0) begin n_err++; $display("FAIL reset_b got=%h want=0", obs(1)); end
    @(negedge clk_5mhz);
    deser_reset_n = 1'b1;
    mdl_reset(0);
    mdl_reset(1);
  endtask

  task automatic test_single();
    bit acc = 0;
    int acc_c = -1, done_c = -1, en_n = 0;
    apply_reset();
    ifa.req_addr = {8'($urandom), 8'h1A};
    ifa.req_data = {16'($urandom), 16'hBEEF};
    for (int c = 0; c < 52; c++) begin
      @(negedge clk_5mhz);
      ifa.req_valid = acc ? 2'b00 : 2'b01;
      #1; mdl_eval(0); n_vec++;
      if (obs(0) !== e_vec[0]) begin
        n_err++; $display("FAIL single c=%0d got=%h want=%h", c, obs(0), e_vec[0]);
      end
      if (ifa.req_ready[0]) begin acc = 1; acc_c = c; end
      if (ifa.cmd_done) done_c = c;
      if (ifa.ti_roic_reg_addr == 16'h801A) en_n++;
      @(posedge clk_5mhz); mdl_step(0);
    end
    n_vec++;
    if (done_c - acc_c !== 46) begin
      n_err++; $display("FAIL single_latency got=%0d want=46", done_c - acc_c);
    end
    n_vec++;
    if (en_n !== 4) begin n_err++; $display("FAIL single_strobe got=%0d want=4", en_n); end
  endtask

  task automatic test_round_robin();
    int ids[$], cyc[$];
    int run = 0, max_run = 0;
    int exp_ord[4] = '{0, 1, 0, 1};
    apply_reset();
    for (int c = 0; c < 190; c++) begin
      @(negedge clk_5mhz);
      ifa.req_valid = (ids.size() < 4) ? 2'b11 : 2'b00;
      ifa.req_addr  = 16'($urandom);
      ifa.req_data  = $urandom;
      #1; mdl_eval(0); n_vec++;
      if (obs(0) !== e_vec[0]) begin
        n_err++; $display("FAIL rr c=%0d got=%h want=%h", c, obs(0), e_vec[0]);
      end
      if (ifa.req_ready != 0) begin ids.push_back(ifa.req_ready[1] ? 1 : 0); cyc.push_back(c); end
      run = ifa.ti_roic_reg_addr[15] ? run + 1 : 0;
      if (run > max_run) max_run = run;
      @(posedge clk_5mhz); mdl_step(0);
    end
    n_vec++;
    if (ids.size() !== 4) begin
      n_err++; $display("FAIL rr_count got=%0d want=4", ids.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_vec++;
        if (ids[k] !== exp_ord[k]) begin
          n_err++; $display("FAIL rr_order k=%0d got=%0d want=%0d", k, ids[k], exp_ord[k]);
        end
        if (k > 0) begin
          n_vec++;
          if (cyc[k] - cyc[k-1] !== 47) begin
            n_err++; $display("FAIL rr_period k=%0d got=%0d want=47", k, cyc[k] - cyc[k-1]);
          end
        end
      end
    end
    n_vec++;
    if (max_run !== 4) begin n_err++; $display("FAIL rr_enable_run got=%0d want=4", max_run); end
  endtask

  task automatic test_hold_off();
    bit acc0 = 0, done_seen = 0;
    int g1_c = -1;
    apply_reset();
    ifa.req_addr = 16'($urandom);
    ifa.req_data = $urandom;
    for (int c = 0; c < 110; c++) begin
      @(negedge clk_5mhz);
      ifa.req_valid = {1'b1, !acc0};
      ifa.hold_off  = (c >= 3 && c < 60);
      #1; mdl_eval(0); n_vec++;
      if (obs(0) !== e_vec[0]) begin
        n_err++; $display("FAIL hold c=%0d got=%h want=%h", c, obs(0), e_vec[0]);
      end
      if (ifa.req_ready[0]) acc0 = 1;
      if (ifa.req_ready[1] && g1_c < 0) g1_c = c;
      if (ifa.cmd_done && c == 46) done_seen = 1;
      @(posedge clk_5mhz); mdl_step(0);
    end
    n_vec++;
    if (!done_seen) begin n_err++; $display("FAIL hold_done got=0 want=1 at c=46"); end
    n_vec++;
    if (g1_c !== 60) begin n_err++; $display("FAIL hold_grant got=%0d want=60", g1_c); end
  endtask

  task automatic test_input_change();
    bit acc = 0;
    int acc_c = -1;
    apply_reset();
    ifa.req_addr = {8'($urandom), 8'h10};
    ifa.req_data = $urandom;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk_5mhz);
      if (acc && c == acc_c + 1) ifa.req_addr[7:0] = 8'h55;
      ifa.req_valid = acc ? 2'b00 : 2'b01;
      #1; mdl_eval(0); n_vec++;
      if (obs(0) !== e_vec[0]) begin
        n_err++; $display("FAIL chg c=%0d got=%h want=%h", c, obs(0), e_vec[0]);
      end
      if (ifa.busy) begin
        n_vec++;
        if (ifa.ti_roic_reg_addr[7:0] !== 8'h10) begin
          n_err++; $display("FAIL chg_hold c=%0d got=%h want=10", c, ifa.ti_roic_reg_addr[7:0]);
        end
      end
      if (ifa.req_ready[0]) begin acc = 1; acc_c = c; end
      @(posedge clk_5mhz); mdl_step(0);
    end
  endtask

  task automatic test_reset_mid_strobe();
    bit acc = 0, found = 0;
    int c = 0;
    apply_reset();
    ifa.req_addr = 16'($urandom);
    ifa.req_data = $urandom;
    while (!found && c < 20) begin
      @(negedge clk_5mhz);
      ifa.req_valid = acc ? 2'b00 : 2'b01;
      #1; mdl_eval(0); n_vec++;
      if (obs(0) !== e_vec[0]) begin
        n_err++; $display("FAIL rst_pre c=%0d got=%h want=%h", c, obs(0), e_vec[0]);
      end
      if (ifa.req_ready[0]) acc = 1;
      if (ifa.ti_roic_reg_addr[15]) found = 1;
      else begin @(posedge clk_5mhz); mdl_step(0); end
      c++;
    end
    n_vec++;
    if (!found) begin n_err++; $display("FAIL rst_wait_strobe timeout after %0d cycles", c); end
    #1 deser_reset_n = 1'b0;
    #1; n_vec++;
    if ({ifa.ti_roic_reg_addr, ifa.busy, ifa.cmd_done} !== 18'h0) begin
      n_err++; $display("FAIL rst_async got=%h want=0", {ifa.ti_roic_reg_addr, ifa.busy, ifa.cmd_done});
    end
    mdl_reset(0);
    mdl_reset(1);
    @(negedge clk_5mhz);
    deser_reset_n = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk_5mhz);
      ifa.req_valid = (k == 50) ? 2'b11 : 2'b00;
      #1; mdl_eval(0); n_vec++;
      if (obs(0) !== e_vec[0]) begin
        n_err++; $display("FAIL rst_post k=%0d got=%h want=%h", k, obs(0), e_vec[0]);
      end
      if (k == 50) begin
        n_vec++;
        if (ifa.req_ready !== 2'b01) begin
          n_err++; $display("FAIL rst_ptr got=%b want=01", ifa.req_ready);
        end
      end
      @(posedge clk_5mhz); mdl_step(0);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 700; c++) begin
      @(negedge clk_5mhz);
      ifa.req_valid = 2'($urandom_range(0, 3));
      ifa.hold_off  = ($urandom_range(0, 7) == 0);
      ifa.req_addr  = 16'($urandom);
      ifa.req_data  = $urandom;
      #1; mdl_eval(0); n_vec++;
      if (obs(0) !== e_vec[0]) begin
        n_err++; $display("FAIL rand c=%0d got=%h want=%h", c, obs(0), e_vec[0]);
      end
      @(posedge clk_5mhz); mdl_step(0);
    end
  endtask

  task automatic test_param_sweep();
    int ids[$], cyc[$];
    int exp_ord[4] = '{0, 1, 2, 0};
    apply_reset();
    for (int c = 0; c < 230; c++) begin
      @(negedge clk_5mhz);
      if (c < 21) begin
        ifb.req_valid = 3'b111;
        ifb.hold_off  = 1'b0;
      end else begin
        ifb.req_valid = 3'($urandom_range(0, 7));
        ifb.hold_off  = ($urandom_range(0, 5) == 0);
      end
      ifb.req_addr = 24'($urandom);
      ifb.req_data = {16'($urandom), 32'($urandom)};
      #1; mdl_eval(1); n_vec++;
      if (obs(1) !== e_vec[1]) begin
        n_err++; $display("FAIL sweep c=%0d got=%h want=%h", c, obs(1), e_vec[1]);
      end
      if (c < 21 && ifb.req_ready != 0) begin
        ids.push_back(ifb.req_ready[2] ? 2 : (ifb.req_ready[1] ? 1 : 0));
        cyc.push_back(c);
      end
      @(posedge clk_5mhz); mdl_step(1);
    end
    n_vec++;
    if (ids.size() < 4) begin
      n_err++; $display("FAIL sweep_count got=%0d want>=4", ids.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_vec++;
        if (ids[k] !== exp_ord[k]) begin
          n_err++; $display("FAIL sweep_order k=%0d got=%0d want=%0d", k, ids[k], exp_ord[k]);
        end
        if (k > 0) begin
          n_vec++;
          if (cyc[k] - cyc[k-1] !== 5) begin
            n_err++; $display("FAIL sweep_period k=%0d got=%0d want=5", k, cyc[k] - cyc[k-1]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_hold_off();
    test_input_change();
    test_reset_mid_strobe();
    test_random();
    test_param_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired: %0d vectors, %0d miscompares", n_vec, n_err);
    $fatal(1, "watchdog");
  end
endmodule
